// File: rtl/pipe_pkg.sv
// Shared encodings for the EX-stage pipeline control slice.
// Optional hazard/flush counters are enabled with HAZARD_PERF_CNT_EN.
package pipe_pkg;

    localparam int DWIDTH_DEF = 32;

    localparam logic [2:0] J_TYPE_NOP = 3'd0;
    localparam logic [2:0] J_TYPE_BEQ = 3'd1;
    localparam logic [2:0] J_TYPE_JAL = 3'd2;
    localparam logic [2:0] J_TYPE_JR  = 3'd3;
    localparam logic [2:0] J_TYPE_J   = 3'd4;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC  = 2'd2;

    // Control half of the ID/EX register; all-zero is a NOP.
    typedef struct packed {
        logic [3:0] op;
        logic [4:0] rdst_id;
        logic       we_reg;
        logic       we_dmem;
        logic       ssel;
        logic [1:0] wbsel;
        logic [2:0] jump_type;
    } idex_ctrl_t;

    function automatic logic raw_match(input logic [4:0] src, input logic we,
                                       input logic [4:0] dst);
        return we && (src != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Redirect resolution for the EX instruction plus RAW stall detection.
// HAZARD_PERF_CNT_EN adds stall/flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
`ifdef HAZARD_PERF_CNT_EN
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    input  logic [2:0]        ex_jump_type,
    input  logic [DWIDTH-1:0] ex_pc,
    input  logic [DWIDTH-1:0] ex_imm,
    input  logic [DWIDTH-1:0] ex_rs1,
    input  logic [25:0]       ex_jump_addr,
    input  logic              alu_zero,
    input  logic [4:0]        id_rs1_id,
    input  logic [4:0]        id_rs2_id,
    input  logic              ex_we_reg,
    input  logic [4:0]        ex_rdst_id,
    input  logic              mem_we_reg,
    input  logic [4:0]        mem_rdst_id,
    output logic              redirect,
    output logic [DWIDTH-1:0] redirect_pc,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble
);

    logic hazard;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        case (ex_jump_type)
            J_TYPE_BEQ: begin
                redirect    = alu_zero;
                redirect_pc = ex_pc + DWIDTH'(4) + {ex_imm[DWIDTH-3:0], 2'b00};
            end
            J_TYPE_JR: begin
                redirect    = 1'b1;
                redirect_pc = ex_rs1;
            end
            J_TYPE_JAL, J_TYPE_J: begin
                redirect    = 1'b1;
                redirect_pc = {ex_pc[31:28], ex_jump_addr, 2'b00};
            end
            default: ;
        endcase
    end

    // WB-stage producers are covered by regfile write-through, so only EX and MEM count.
    assign hazard = raw_match(id_rs1_id, ex_we_reg,  ex_rdst_id)  ||
                    raw_match(id_rs1_id, mem_we_reg, mem_rdst_id) ||
                    raw_match(id_rs2_id, ex_we_reg,  ex_rdst_id)  ||
                    raw_match(id_rs2_id, mem_we_reg, mem_rdst_id);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (redirect) begin
            // ID holds a wrong-path instruction, so its hazard is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!redirect && hazard) stall_cnt <= stall_cnt + 32'd1;
            if (redirect)            flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/pipe_ex_ctrl.sv
// ID/EX and EX/MEM pipeline registers with interlock and redirect control.
// HAZARD_PERF_CNT_EN exposes stall_cnt/flush_cnt from the hazard unit.
module pipe_ex_ctrl
    import pipe_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] id_pc,
    input  logic [3:0]        id_op,
    input  logic [DWIDTH-1:0] id_imm,
    input  logic [25:0]       id_jump_addr,
    input  logic [DWIDTH-1:0] id_rs1,
    input  logic [DWIDTH-1:0] id_rs2,
    input  logic [4:0]        id_rs1_id,
    input  logic [4:0]        id_rs2_id,
    input  logic [4:0]        id_rdst_id,
    input  logic              id_we_reg,
    input  logic              id_we_dmem,
    input  logic              id_ssel,
    input  logic [1:0]        id_wbsel,
    input  logic [2:0]        id_jump_type,
    output logic [DWIDTH-1:0] ex_pc,
    output logic [DWIDTH-1:0] ex_imm,
    output logic [DWIDTH-1:0] ex_rs1,
    output logic [DWIDTH-1:0] ex_rs2,
    output logic [3:0]        ex_op,
    output logic [25:0]       ex_jump_addr,
    output logic [4:0]        ex_rdst_id,
    output logic              ex_we_reg,
    output logic              ex_we_dmem,
    output logic              ex_ssel,
    output logic [1:0]        ex_wbsel,
    output logic [2:0]        ex_jump_type,
    input  logic [DWIDTH-1:0] alu_out,
    input  logic              alu_zero,
    output logic [DWIDTH-1:0] mem_pc,
    output logic [DWIDTH-1:0] mem_rd,
    output logic [DWIDTH-1:0] mem_rs2,
    output logic [4:0]        mem_rdst_id,
    output logic              mem_we_reg,
    output logic              mem_we_dmem,
    output logic [1:0]        mem_wbsel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              redirect,
    output logic [DWIDTH-1:0] redirect_pc
);

    idex_ctrl_t id_ctrl, ex_ctrl;
    logic       idex_bubble;

    assign id_ctrl = '{op: id_op, rdst_id: id_rdst_id, we_reg: id_we_reg,
                       we_dmem: id_we_dmem, ssel: id_ssel, wbsel: id_wbsel,
                       jump_type: id_jump_type};

    always_ff @(posedge clk or posedge rst) begin
        if (rst || idex_bubble) begin
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_jump_addr <= '0;
            ex_ctrl      <= '0;
        end else begin
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_jump_addr <= id_jump_addr;
            ex_ctrl      <= id_ctrl;
        end
    end

    assign ex_op        = ex_ctrl.op;
    assign ex_rdst_id   = ex_ctrl.rdst_id;
    assign ex_we_reg    = ex_ctrl.we_reg;
    assign ex_we_dmem   = ex_ctrl.we_dmem;
    assign ex_ssel      = ex_ctrl.ssel;
    assign ex_wbsel     = ex_ctrl.wbsel;
    assign ex_jump_type = ex_ctrl.jump_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pc      <= '0;
            mem_rd      <= '0;
            mem_rs2     <= '0;
            mem_rdst_id <= '0;
            mem_we_reg  <= 1'b0;
            mem_we_dmem <= 1'b0;
            mem_wbsel   <= '0;
        end else begin
            mem_pc      <= ex_pc;
            mem_rd      <= alu_out;
            mem_rs2     <= ex_rs2;
            mem_rdst_id <= ex_ctrl.rdst_id;
            mem_we_reg  <= ex_ctrl.we_reg;
            mem_we_dmem <= ex_ctrl.we_dmem;
            mem_wbsel   <= ex_ctrl.wbsel;
        end
    end

    pipe_hazard_unit #(.DWIDTH(DWIDTH)) u_hazard (
`ifdef HAZARD_PERF_CNT_EN
        .clk          (clk),
        .rst          (rst),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .ex_jump_type (ex_ctrl.jump_type),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_jump_addr (ex_jump_addr),
        .alu_zero     (alu_zero),
        .id_rs1_id    (id_rs1_id),
        .id_rs2_id    (id_rs2_id),
        .ex_we_reg    (ex_ctrl.we_reg),
        .ex_rdst_id   (ex_ctrl.rdst_id),
        .mem_we_reg   (mem_we_reg),
        .mem_rdst_id  (mem_rdst_id),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble)
    );

endmodule

// File: tb/tb_pipe_ex_ctrl.sv
// Directed bench for pipe_ex_ctrl: reset, pass-through, stalls, redirects.
module tb_pipe_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_pc, id_imm, id_rs1, id_rs2;
    logic [3:0]  id_op;
    logic [25:0] id_jump_addr;
    logic [4:0]  id_rs1_id, id_rs2_id, id_rdst_id;
    logic        id_we_reg, id_we_dmem, id_ssel;
    logic [1:0]  id_wbsel;
    logic [2:0]  id_jump_type;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
    logic [3:0]  ex_op;
    logic [25:0] ex_jump_addr;
    logic [4:0]  ex_rdst_id;
    logic        ex_we_reg, ex_we_dmem, ex_ssel;
    logic [1:0]  ex_wbsel;
    logic [2:0]  ex_jump_type;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] mem_pc, mem_rd, mem_rs2;
    logic [4:0]  mem_rdst_id;
    logic        mem_we_reg, mem_we_dmem;
    logic [1:0]  mem_wbsel;
    logic        pc_write, ifid_write, ifid_flush, redirect;
    logic [31:0] redirect_pc;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ex_ctrl dut (
        .clk(clk), .rst(rst),
        .id_pc(id_pc), .id_op(id_op), .id_imm(id_imm), .id_jump_addr(id_jump_addr),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_rdst_id(id_rdst_id), .id_we_reg(id_we_reg), .id_we_dmem(id_we_dmem),
        .id_ssel(id_ssel), .id_wbsel(id_wbsel), .id_jump_type(id_jump_type),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_op(ex_op),
        .ex_jump_addr(ex_jump_addr), .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg),
        .ex_we_dmem(ex_we_dmem), .ex_ssel(ex_ssel), .ex_wbsel(ex_wbsel),
        .ex_jump_type(ex_jump_type), .alu_out(alu_out), .alu_zero(alu_zero),
        .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rs2(mem_rs2), .mem_rdst_id(mem_rdst_id),
        .mem_we_reg(mem_we_reg), .mem_we_dmem(mem_we_dmem), .mem_wbsel(mem_wbsel),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_pc = '0; id_op = '0; id_imm = '0; id_jump_addr = '0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_id = '0; id_rs2_id = '0; id_rdst_id = '0;
        id_we_reg = 0; id_we_dmem = 0; id_ssel = 0; id_wbsel = '0; id_jump_type = '0;
    endtask

    initial begin
        rst = 1'b1;
        alu_out = '0;
        alu_zero = 1'b0;
        clr_id();
        tick();
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        rst = 1'b0;

        // Pass-through into ID/EX, then EX/MEM
        id_pc = 32'h40; id_imm = 32'd5; id_we_reg = 1'b1; id_rdst_id = 5'd7;
        id_op = 4'd3; id_wbsel = 2'd1; id_rs2 = 32'hAA;
        tick();
        chk("pt_ex_pc", ex_pc, 32'h40);
        chk("pt_ex_imm", ex_imm, 32'd5);
        chk("pt_ex_we_reg", {31'd0, ex_we_reg}, 32'd1);
        chk("pt_ex_rdst", {27'd0, ex_rdst_id}, 32'd7);
        chk("pt_ex_op", {28'd0, ex_op}, 32'd3);
        alu_out = 32'h1234;
        tick();
        chk("pt_mem_rd", mem_rd, 32'h1234);
        chk("pt_mem_pc", mem_pc, 32'h40);
        chk("pt_mem_rs2", mem_rs2, 32'hAA);
        chk("pt_mem_rdst", {27'd0, mem_rdst_id}, 32'd7);
        chk("pt_mem_wbsel", {30'd0, mem_wbsel}, 32'd1);

        // Asynchronous reset mid-cycle with both stages loaded
        #2 rst = 1'b1;
        #1;
        chk("arst_ex_pc", ex_pc, 32'h0);
        chk("arst_ex_we", {31'd0, ex_we_reg}, 32'd0);
        chk("arst_mem_rd", mem_rd, 32'h0);
        chk("arst_mem_pc", mem_pc, 32'h0);
        chk("arst_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
        rst = 1'b0;
        clr_id();
        alu_out = '0;

        // RAW stall: producer r3 in EX, consumer in ID
        id_we_reg = 1'b1; id_rdst_id = 5'd3;
        tick();
        clr_id();
        id_rs1_id = 5'd3; id_pc = 32'h44; id_we_reg = 1'b1; id_rdst_id = 5'd4;
        #1;
        chk("raw_ex_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b000);
        tick();
        chk("raw_bubble_we", {31'd0, ex_we_reg}, 32'd0);
        chk("raw_bubble_pc", ex_pc, 32'h0);
        chk("raw_mem_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b000);
        tick();
        chk("raw_wb_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
        tick();
        chk("raw_release_pc", ex_pc, 32'h44);
        chk("raw_release_rdst", {27'd0, ex_rdst_id}, 32'd4);
        clr_id();
        id_we_reg = 1'b1; id_rdst_id = 5'd0;
        tick();
        clr_id();
        #1;
        chk("r0_no_stall", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
        // rs2 match against EX producer
        id_we_reg = 1'b1; id_rdst_id = 5'd9;
        tick();
        clr_id();
        id_rs2_id = 5'd9;
        #1;
        chk("raw_rs2", {30'd0, pc_write, ifid_write}, 32'b00);
        clr_id();
        tick();
        tick();

        // BEQ taken: 0x100 + 4 + (-2<<2) = 0xFC
        id_pc = 32'h100; id_imm = 32'hFFFF_FFFE; id_jump_type = 3'd1;
        tick();
        clr_id();
        id_pc = 32'h200; id_we_reg = 1'b1;
        alu_zero = 1'b1;
        #1;
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_target", redirect_pc, 32'hFC);
        chk("beq_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b111);
        tick();
        chk("beq_flush_pc", ex_pc, 32'h0);
        chk("beq_flush_we", {31'd0, ex_we_reg}, 32'd0);
        alu_zero = 1'b0;
        clr_id();
        id_pc = 32'h100; id_imm = 32'hFFFF_FFFE; id_jump_type = 3'd1;
        tick();
        clr_id();
        #1;
        chk("beq_nt_redirect", {31'd0, redirect}, 32'd0);
        chk("beq_nt_flush", {31'd0, ifid_flush}, 32'd0);

        // JR
        id_jump_type = 3'd3; id_rs1 = 32'h2000;
        tick();
        clr_id();
        #1;
        chk("jr_redirect", {31'd0, redirect}, 32'd1);
        chk("jr_target", redirect_pc, 32'h2000);
        tick();

        // J keeps the upper PC nibble
        id_jump_type = 3'd4; id_pc = 32'h3000_0010; id_jump_addr = 26'h40;
        tick();
        clr_id();
        #1;
        chk("j_redirect", {31'd0, redirect}, 32'd1);
        chk("j_target", redirect_pc, 32'h3000_0100);
        tick();

        // Undefined jump type
        id_jump_type = 3'd5; id_pc = 32'h500; id_rs1 = 32'h77;
        tick();
        clr_id();
        #1;
        chk("undef_redirect", {31'd0, redirect}, 32'd0);
        chk("undef_target", redirect_pc, 32'h0);

        // Taken JAL in EX overrides a MEM-stage hazard on rs1
        id_we_reg = 1'b1; id_rdst_id = 5'd6;
        tick();
        clr_id();
        id_jump_type = 3'd2; id_pc = 32'h0; id_jump_addr = 26'h10;
        tick();
        clr_id();
        id_rs1_id = 5'd6; id_pc = 32'h300;
        #1;
        chk("sim_mem_rdst", {27'd0, mem_rdst_id}, 32'd6);
        chk("sim_ctrl", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b111);
        chk("sim_target", redirect_pc, 32'h40);
        tick();
        chk("sim_bubble_jt", {29'd0, ex_jump_type}, 32'd0);
        chk("sim_bubble_pc", ex_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
